// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive half of the UART. Deserialises 8N1 frames from i_rx using the
//   shared 16x oversampling tick, checks the stop bit, and queues good bytes
//   into a show-ahead circular FIFO. Sticky flags report dropped bytes.
//
// Ports
//   i_clock      system clock
//   i_reset      synchronous, active-low reset
//   i_rx         raw serial input (asynchronous, idle high)
//   i_s_tick     one-cycle tick at 16x the bit rate
//   i_rd         pop strobe; pops the head byte when not empty
//   i_clr_err    clears o_frame_err and o_overrun
//   o_r_data     head-of-FIFO byte (valid while o_empty = 0)
//   o_empty      FIFO holds no bytes
//   o_full       FIFO holds 2^ADDR_W bytes
//   o_count      number of bytes stored (0 .. 2^ADDR_W)
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a good byte arrived while the FIFO was full
//
// States
//   ST_IDLE  | line idle, waiting for a falling edge on the synchronised rx
//   ST_START | counting to the middle of the start bit to confirm it
//   ST_DATA  | sampling data bits, LSB first, every 16 ticks
//   ST_STOP  | waiting for the stop-bit sample point, then push or flag
module uart_rx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx,
    input  logic              i_s_tick,
    input  logic              i_rd,
    input  logic              i_clr_err,
    output logic [7:0]        o_r_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int              N_W         = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [N_W-1:0]  N_LAST      = N_W'(DBIT - 1);
    localparam logic [3:0]      S_MID_START = 4'd7;
    localparam logic [3:0]      S_BIT_LAST  = 4'd15;
    localparam logic [3:0]      S_STOP_LAST = 4'(SB_TICK - 1);
    localparam int              DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W:0] COUNT_FULL  = {1'b1, {ADDR_W{1'b0}}};

    logic              r_rx_meta;
    logic              r_rx_s;
    logic [1:0]        r_state;
    logic [3:0]        r_s;
    logic [N_W-1:0]    r_n;
    logic [DBIT-1:0]   r_b;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_frame_err;
    logic              r_overrun;

    logic       w_full;
    logic       w_empty;
    logic       w_stop_eval;
    logic       w_stop_good;
    logic       w_stop_bad;
    logic       w_push;
    logic       w_pop;
    logic       w_overrun_evt;
    logic [7:0] w_byte;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_s     <= 4'd0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= 4'd0;
                    end
                end
                ST_START: begin
                    if (i_s_tick) begin
                        if (r_s == S_MID_START) begin
                            // Line back high at mid start bit: treat as a glitch.
                            if (!r_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= 4'd0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_s_tick) begin
                        if (r_s == S_BIT_LAST) begin
                            r_s <= 4'd0;
                            r_b <= {r_rx_s, r_b[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_s_tick) begin
                        if (r_s == S_STOP_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_full        = (r_count == COUNT_FULL);
        w_empty       = (r_count == '0);
        w_stop_eval   = (r_state == ST_STOP) && i_s_tick && (r_s == S_STOP_LAST);
        w_stop_good   = w_stop_eval && r_rx_s;
        w_stop_bad    = w_stop_eval && !r_rx_s;
        w_pop         = i_rd && !w_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push        = w_stop_good && (!w_full || i_rd);
        w_overrun_evt = w_stop_good && w_full && !i_rd;
        w_byte        = 8'(r_b);
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clock) begin
        if (i_reset && w_push) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_r_data    = r_mem[r_rd_ptr];
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_count     = r_count;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receive path for the Basys 3 UART design. It is the receive-side counterpart of the transmit FIFO path. It deserialises 8N1 frames from `rx` using the shared 16x oversampling baud tick, checks the stop bit, and queues good bytes into an internal FIFO. A consumer drains the FIFO with a `read_uart`-style read strobe. Sticky framing-error and overrun flags report dropped bytes.

## Interface
- `DBIT`, default 8: data bits per frame, LSB first.
- `SB_TICK`, default 16: s_ticks spent in the stop bit (16 = one stop bit).
- `ADDR_W`, default 4: FIFO address width; depth = 2^ADDR_W (16).

- `clock`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-low reset.
- `rx`  in  1  raw serial input (asynchronous, idle high).
- `s_tick`  in  1  one-cycle baud tick at 16x bit rate (from `mod_m_counter`, M=54).
- `rd`  in  1  pop strobe; pops the head byte when not empty.
- `r_data`  out  8  head-of-FIFO byte (show-ahead).
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds 2^ADDR_W bytes.
- `count`  out  ADDR_W+1  number of bytes stored.
- `frame_err`  out  1  sticky: a stop bit sampled low.
- `overrun`  out  1  sticky: a good byte arrived while the FIFO was full.
- `clr_err`  in  1  clears `frame_err` and `overrun`.

## Operation
- Input sync: two flops on `rx` into `rx_s`; both reset to 1. Only `rx_s` is used.
- FSM states: IDLE, START, DATA, STOP. Counters: `s` (4 bit, tick count) and `n` (bit index). Shift register: `b` (DBIT).
- FSM advances only on cycles with `s_tick`=1, except IDLE.
- IDLE: `rx_s`=0 → START, `s`←0.
- START: on a tick with `s`=7 (mid start bit):
  - `rx_s`=0 → DATA, `s`←0, `n`←0.
  - `rx_s`=1 → IDLE (glitch rejected, nothing pushed, no flag).
  - Otherwise on a tick, `s`++.
- DATA: on a tick with `s`=15: `s`←0, `b`←{`rx_s`, `b`[DBIT-1:1]}. If `n`=DBIT-1 → STOP, else `n`++. Otherwise on a tick, `s`++.
- STOP: on a tick with `s`=SB_TICK-1 → IDLE, and evaluate `rx_s`:
  - `rx_s`=0: set `frame_err`; byte discarded.
  - `rx_s`=1 and (not full, or `rd` in the same cycle): push `b`.
  - `rx_s`=1 and full without `rd`: set `overrun`; byte discarded; FIFO contents unchanged.
- FIFO: circular buffer of 2^ADDR_W × 8 bits with wrapping `wr_ptr`/`rd_ptr` of ADDR_W bits.
  - `count` is tracked explicitly and ranges 0..2^ADDR_W.
  - `rd` while empty is ignored: pointers and `count` unchanged.
  - Push and pop in the same cycle: both happen and `count` is unchanged. This holds when full and also when `count`=1.
  - Push and pop in the same cycle when empty: the pop is ignored and the push happens.
- Flags: `clr_err` clears both flags. If a set event and `clr_err` occur in the same cycle, the set wins.

## Timing
- Reset (`reset`=0 at a `clock` edge) gives: FSM=IDLE, `s`=`n`=0, `b`=0, pointers=0, `count`=0, `empty`=1, `full`=0, `frame_err`=0, `overrun`=0.
- `r_data` is don't-care while `empty`=1. FIFO memory is not reset.
- Reset mid-frame abandons the frame. A partial byte is never pushed.
- Reset takes priority over all other inputs.
- Push latency: the byte is in the FIFO on the `clock` edge of the stop-bit evaluation tick. `empty`, `full` and `count` update on the next cycle's outputs, i.e. registered one cycle after that tick.
- `r_data` is combinational from `mem[rd_ptr]`. After a pop, the next byte appears in the cycle after the `rd` cycle.
- Bit sampling: start bit at tick 8 after the falling edge seen on `rx_s`; data bits at +16 ticks each.
- With M=54 at 100 MHz: 1 bit = 864 clocks and 1 frame ≈ 8640 clocks (115200 baud).
- `rd` is a single-cycle strobe. Holding it high pops one byte per cycle.

## Test plan
- Byte 0xA5 sent at 115200 8N1 → `empty` falls after the stop tick; `r_data`=0xA5, `count`=1. `rd` pulse → `empty`=1, `count`=0. No flags set.
- 4-tick low glitch on `rx` → FSM returns to IDLE; `count`=0; no flags.
- Frame 0x3C with stop bit driven low → `frame_err`=1 and nothing pushed. `clr_err` → `frame_err`=0.
- Send 0x00..0x0F (16 bytes) → `full`=1, `count`=16. Send 0x10 → `overrun`=1, `count` stays 16. Drain → bytes read are 0x00..0x0F in order, with pointers wrapping correctly.
- FIFO full, with `rd` asserted exactly on the stop evaluation tick of byte 0x55 → 0x00 popped, 0x55 pushed, `count`=16, `overrun`=0.
- Reset asserted mid-DATA of byte 0xFF and released, then byte 0x81 sent → only 0x81 appears in the FIFO; `count`=1; flags clear.
